// File: rtl/msrv32_integer_file_if.sv
// msrv32_integer_file_if: read/write port bundle for the integer register file
interface msrv32_integer_file_if #(
  parameter int XLEN = 32,
  parameter int AW = 5
) ();
  logic [AW-1:0] rs_1_addr_in;
  logic [AW-1:0] rs_2_addr_in;
  logic [AW-1:0] rd_addr_in;
  logic wr_en_in;
  logic [XLEN-1:0] rd_in;
  logic [XLEN-1:0] rs_1_out;
  logic [XLEN-1:0] rs_2_out;
  modport master (
    output rs_1_addr_in, rs_2_addr_in, rd_addr_in, wr_en_in, rd_in,
    input rs_1_out, rs_2_out
  );
  modport slave (
    input rs_1_addr_in, rs_2_addr_in, rd_addr_in, wr_en_in, rd_in,
    output rs_1_out, rs_2_out
  );
endinterface

// File: rtl/msrv32_integer_file.sv
// msrv32_integer_file: 2-read/1-write integer register file with write-through bypass and hardwired x0
module msrv32_integer_file #(
  parameter int XLEN = 32,
  parameter int NREGS = 32
) (
  input logic ms_riscv32_mp_clk_in,
  input logic ms_riscv32_mp_rst_in,
  msrv32_integer_file_if.slave rf
);
  logic [XLEN-1:0] regs [NREGS];
  // commit write-back data on the edge; reset wipes every register at once and x0 never takes a write
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in)
    if (ms_riscv32_mp_rst_in)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (rf.wr_en_in && rf.rd_addr_in != '0)
      regs[rf.rd_addr_in] <= rf.rd_in;
  // combinational reads: reset and x0 force zero, a same-cycle write to the read index is forwarded
  always_comb begin
    rf.rs_1_out = (ms_riscv32_mp_rst_in || rf.rs_1_addr_in == '0) ? '0 :
                  (rf.wr_en_in && rf.rs_1_addr_in == rf.rd_addr_in) ? rf.rd_in : regs[rf.rs_1_addr_in];
    rf.rs_2_out = (ms_riscv32_mp_rst_in || rf.rs_2_addr_in == '0) ? '0 :
                  (rf.wr_en_in && rf.rs_2_addr_in == rf.rd_addr_in) ? rf.rd_in : regs[rf.rs_2_addr_in];
  end
endmodule

// File: tb/tb_msrv32_integer_file.sv
// tb_msrv32_integer_file: randomized and directed checks of the register file against an array model
module tb_msrv32_integer_file;
  logic clk;
  logic rst;
  int n_cmp;
  int n_err;
  logic [31:0] model [32];
  msrv32_integer_file_if #(.XLEN(32), .AW(5)) rf_if ();
  msrv32_integer_file #(.XLEN(32), .NREGS(32)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .rf(rf_if)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (rf_if.wr_en_in && a == rf_if.rd_addr_in) return rf_if.rd_in;
    return model[a];
  endfunction
  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask
  task automatic do_cycle(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    rf_if.wr_en_in = we;
    rf_if.rd_addr_in = rd;
    rf_if.rd_in = d;
    rf_if.rs_1_addr_in = a1;
    rf_if.rs_2_addr_in = a2;
    #1;
    check({tag, "_p1"}, rf_if.rs_1_out, expect_rd(a1));
    check({tag, "_p2"}, rf_if.rs_2_out, expect_rd(a2));
    @(posedge clk);
    if (!rst && we && rd != 5'd0) model[rd] = d;
  endtask
  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      logic [4:0] rd;
      logic [4:0] a1;
      logic [4:0] a2;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      do_cycle("rand", 1'($urandom_range(0, 1)), rd, $urandom, a1, a2);
    end
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_model();
    rst = 1'b1;
    rf_if.wr_en_in = 1'b0;
    rf_if.rd_addr_in = '0;
    rf_if.rd_in = '0;
    rf_if.rs_1_addr_in = 5'd1;
    rf_if.rs_2_addr_in = 5'd31;
    #2;
    check("rst_init_p1", rf_if.rs_1_out, 32'h0);
    check("rst_init_p2", rf_if.rs_2_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    random_phase(300);
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      rf_if.rs_1_addr_in = 5'(i);
      rf_if.rs_2_addr_in = 5'(i);
      rf_if.rd_addr_in = 5'(i);
      rf_if.wr_en_in = 1'b1;
      rf_if.rd_in = $urandom | 32'h1;
      #1;
      check("rst_sweep_p1", rf_if.rs_1_out, 32'h0);
      check("rst_sweep_p2", rf_if.rs_2_out, 32'h0);
    end
    @(negedge clk);
    #2;
    rf_if.wr_en_in = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i += 4) do_cycle("post_rst", 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
    do_cycle("wr_x5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd6, 5'd0);
    do_cycle("rd_x5", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("x5_const", rf_if.rs_1_out, 32'hDEADBEEF);
    do_cycle("rd_x6", 1'b0, 5'd0, 32'h0, 5'd6, 5'd6);
    check("x6_const", rf_if.rs_2_out, 32'h0);
    do_cycle("wr_x0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("x0_nobyp", rf_if.rs_1_out, 32'h0);
    do_cycle("rd_x0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("x0_after", rf_if.rs_1_out, 32'h0);
    do_cycle("wr_x7", 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    do_cycle("byp_x7", 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
    check("byp_x7_const", rf_if.rs_2_out, 32'h22222222);
    do_cycle("rd_x7", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    check("x7_const", rf_if.rs_1_out, 32'h22222222);
    do_cycle("wr_x9", 1'b1, 5'd9, 32'h00009999, 5'd0, 5'd0);
    do_cycle("flush_x9", 1'b0, 5'd9, 32'hABCD0000, 5'd9, 5'd9);
    check("flush_x9_const", rf_if.rs_1_out, 32'h00009999);
    do_cycle("rd_x9", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    check("x9_const", rf_if.rs_1_out, 32'h00009999);
    do_cycle("wr_x3", 1'b1, 5'd3, 32'h5A5A5A5A, 5'd0, 5'd0);
    do_cycle("rd_x3", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    @(negedge clk);
    rf_if.wr_en_in = 1'b1;
    rf_if.rd_addr_in = 5'd3;
    rf_if.rd_in = 32'h00001234;
    rf_if.rs_1_addr_in = 5'd3;
    rf_if.rs_2_addr_in = 5'd3;
    #1;
    rst = 1'b1;
    clear_model();
    #1;
    check("rst_wr_p1", rf_if.rs_1_out, 32'h0);
    check("rst_wr_p2", rf_if.rs_2_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rf_if.wr_en_in = 1'b0;
    #2;
    rst = 1'b0;
    do_cycle("x3_lost", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("x3_const", rf_if.rs_1_out, 32'h0);
    do_cycle("first_wr", 1'b1, 5'd3, 32'hC0FFEE00, 5'd0, 5'd0);
    do_cycle("rd_first", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("first_wr_const", rf_if.rs_2_out, 32'hC0FFEE00);
    random_phase(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
